// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline: operand forwarding, load-use and branch handling, data-memory wait FSM.
// Optional HAZARD_PERF_EN adds saturating stall-cycle and flush-event counters.
module hazard_ctrl #(
    parameter int          REG_ADDR_W  = 5,
    parameter int          MEM_LATENCY = 1,
    parameter logic [1:0]  LOAD_SRC    = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1_D,
    input  logic [REG_ADDR_W-1:0] Rs2_D,
    input  logic [REG_ADDR_W-1:0] Rs1_E,
    input  logic [REG_ADDR_W-1:0] Rs2_E,
    input  logic [REG_ADDR_W-1:0] Rd_E,
    input  logic [1:0]            resultSrc_E,
    input  logic                  PCsrc_E,
    input  logic [REG_ADDR_W-1:0] Rd_M,
    input  logic                  regWrite_M,
    input  logic                  memReq_M,
    input  logic [REG_ADDR_W-1:0] Rd_W,
    input  logic                  regWrite_W,
    output logic [1:0]            forwardA_E,
    output logic [1:0]            forwardB_E,
    output logic                  stall_F,
    output logic                  stall_D,
    output logic                  stall_E,
    output logic                  stall_M,
    output logic                  flush_D,
    output logic                  flush_E,
    output logic                  flush_W
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stallCycles,
    output logic [31:0]           flushEvents
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

    localparam logic       LAT_GT1    = (MEM_LATENCY > 1);
    localparam int         CNT_INIT_I = (MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0;
    localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

    state_t     r_state, w_next;
    logic [3:0] r_cnt, w_cnt_next;
    logic       w_memStall;
    logic       w_luh;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        if (we_m && (rd_m != '0) && (rd_m == rs))
            return 2'b10;
        else if (we_w && (rd_w != '0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        forwardA_E = fwd_sel(Rs1_E, Rd_M, regWrite_M, Rd_W, regWrite_W);
        forwardB_E = fwd_sel(Rs2_E, Rd_M, regWrite_M, Rd_W, regWrite_W);
    end

    assign w_luh = (resultSrc_E == LOAD_SRC) && (Rd_E != '0) &&
                   ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    // Memory wait FSM: IDLE cycle plus WAIT cycles give MEM_LATENCY-1 stalls, RELEASE lets M drain
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_memStall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (memReq_M && LAT_GT1) begin
                    w_memStall = 1'b1;
                    w_cnt_next = CNT_INIT;
                    w_next     = (CNT_INIT != 4'd0) ? S_WAIT : S_RELEASE;
                end
            end
            S_WAIT: begin
                w_memStall = 1'b1;
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1)
                    w_next = S_RELEASE;
            end
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Priority: memory stall freezes everything, then branch redirect, then load-use bubble
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_W = 1'b0;
        if (!rst) begin
            if (w_memStall) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end else if (PCsrc_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (w_luh) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stallCycles, r_flushEvents;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles <= 32'd0;
            r_flushEvents <= 32'd0;
        end else begin
            if (stall_F && (r_stallCycles != 32'hFFFF_FFFF))
                r_stallCycles <= r_stallCycles + 32'd1;
            if (flush_E && (r_flushEvents != 32'hFFFF_FFFF))
                r_flushEvents <= r_flushEvents + 32'd1;
        end
    end

    assign stallCycles = r_stallCycles;
    assign flushEvents = r_flushEvents;
`endif

endmodule
